// File: rtl/cmd_sequencer.sv
// Command sequencer: takes a received UART command, hands it to a downstream
// executor, then transmits one ACK/NAK byte. Optional EXEC watchdog: CMD_TIMEOUT_EN.
module cmd_sequencer #(
  parameter logic [7:0]  ACK_BYTE       = 8'hA5,
  parameter logic [7:0]  NAK_BYTE       = 8'h5A,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_rdy,
  input  logic [23:0] cmd,
  output logic        clr_cmd_rdy,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        op_vld,
  output logic [7:0]  opcode,
  output logic [15:0] op_data,
  input  logic        op_done,
  input  logic        op_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, SEND, WAIT_TX} state_t;

  state_t      state, state_nxt;
  logic [7:0]  opcode_nxt;
  logic [15:0] op_data_nxt;
  logic [7:0]  tx_data_nxt;

`ifdef CMD_TIMEOUT_EN
  logic [15:0] wdog_cnt, wdog_nxt;
  logic        wdog_hit;

  // Counter holds the number of completed EXEC cycles, so the limit is
  // reached during the TIMEOUT_CYCLES-th EXEC cycle.
  assign wdog_hit = (wdog_cnt == TIMEOUT_CYCLES - 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wdog_cnt <= 16'h0000;
    else     wdog_cnt <= wdog_nxt;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      opcode  <= 8'h00;
      op_data <= 16'h0000;
      tx_data <= 8'h00;
    end else begin
      state   <= state_nxt;
      opcode  <= opcode_nxt;
      op_data <= op_data_nxt;
      tx_data <= tx_data_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    opcode_nxt  = opcode;
    op_data_nxt = op_data;
    tx_data_nxt = tx_data;
    clr_cmd_rdy = 1'b0;
    trmt        = 1'b0;
    op_vld      = 1'b0;
`ifdef CMD_TIMEOUT_EN
    wdog_nxt    = wdog_cnt;
`endif
    case (state)
      IDLE: begin
        // Gated with rst so the receiver is never cleared while held in reset.
        if (cmd_rdy && !rst) begin
          clr_cmd_rdy = 1'b1;
          opcode_nxt  = cmd[23:16];
          op_data_nxt = cmd[15:0];
          if (cmd[23:16] != 8'h00) begin
            state_nxt = EXEC;
`ifdef CMD_TIMEOUT_EN
            wdog_nxt  = 16'h0000;
`endif
          end else begin
            tx_data_nxt = NAK_BYTE;
            state_nxt   = SEND;
          end
        end
      end
      EXEC: begin
        op_vld = 1'b1;
`ifdef CMD_TIMEOUT_EN
        wdog_nxt = wdog_cnt + 16'd1;
`endif
        if (op_done) begin
          tx_data_nxt = op_err ? NAK_BYTE : ACK_BYTE;
          state_nxt   = SEND;
        end
`ifdef CMD_TIMEOUT_EN
        else if (wdog_hit) begin
          tx_data_nxt = NAK_BYTE;
          state_nxt   = SEND;
        end
`endif
      end
      SEND: begin
        trmt      = 1'b1;
        state_nxt = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule
